// File: rtl/silife_vga_grid.sv
// silife_vga_grid
//   Game-of-Life VGA renderer. It generates its own VGA timing and draws a
//   WIDTH x HEIGHT cell grid. Each cell is a square of 2**CELL_SHIFT pixels,
//   and the grid starts at screen position (X_OFFSET, Y_OFFSET). During the
//   horizontal blank before each grid line, the row that line needs is copied
//   from the cell array into a line buffer. A generation update therefore
//   never shows up part-way across a line.
//
// Ports
//   clk            pixel clock
//   reset          synchronous, active-high reset
//   i_enable       display cells; latched once per frame at h==0, v==0
//   i_cells        cell states of the selected row, bit n = column n
//   o_row_select   row read address to the cell array
//   o_hsync        horizontal sync, active level SYNC_POL
//   o_vsync        vertical sync, active level SYNC_POL
//   o_pixel        00 background, 01 dead, 10 alive, 11 grid line
//   o_frame_start  one-cycle pulse aligned with the first pixel of a frame
//
// All outputs are registered and describe the counter state of the previous
// cycle, so they are mutually aligned.
module silife_vga_grid #(
    parameter int WIDTH      = 32,
    parameter int HEIGHT     = 32,
    parameter int CELL_SHIFT = 3,
    parameter int X_OFFSET   = 0,
    parameter int Y_OFFSET   = 0,
    parameter int GRID_LINES = 0,
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_enable,
    input  logic [WIDTH-1:0]            i_cells,
    output logic [$clog2(HEIGHT)-1:0]   o_row_select,
    output logic                        o_hsync,
    output logic                        o_vsync,
    output logic [1:0]                  o_pixel,
    output logic                        o_frame_start
);

    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HW        = $clog2(H_TOTAL);
    localparam int VW        = $clog2(V_TOTAL);
    localparam int RW        = $clog2(HEIGHT);
    localparam int CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GRID_W    = WIDTH << CELL_SHIFT;
    localparam int GRID_H    = HEIGHT << CELL_SHIFT;
    localparam int CELL_MASK = (1 << CELL_SHIFT) - 1;
    localparam int HS_START  = H_VISIBLE + H_FP;
    localparam int HS_END    = H_VISIBLE + H_FP + H_SYNC;
    localparam int VS_START  = V_VISIBLE + V_FP;
    localparam int VS_END    = V_VISIBLE + V_FP + V_SYNC;

    // The grid must lie entirely inside the visible area.
    if ((X_OFFSET < 0) || (Y_OFFSET < 0) ||
        (X_OFFSET + GRID_W > H_VISIBLE) || (Y_OFFSET + GRID_H > V_VISIBLE)) begin : g_fit_check
        $error("silife_vga_grid: cell grid does not fit inside the visible region");
    end

    logic [HW-1:0]    h_q, h_d;
    logic [VW-1:0]    v_q, v_d;
    logic             en_q, en_d;
    logic [RW-1:0]    row_q, row_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic [1:0]       pix_q, pix_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             fs_q, fs_d;

    int   h_i, v_i, hx, vy, vn;
    logic frame_first, in_grid, vn_grid;

    always_comb begin
        h_i         = int'(h_q);
        v_i         = int'(v_q);
        hx          = h_i - X_OFFSET;
        vy          = v_i - Y_OFFSET;
        vn          = (v_i == V_TOTAL - 1) ? 0 : v_i + 1;
        frame_first = (h_i == 0) && (v_i == 0);
        in_grid     = (hx >= 0) && (hx < GRID_W) && (vy >= 0) && (vy < GRID_H);
        vn_grid     = (vn >= Y_OFFSET) && (vn < Y_OFFSET + GRID_H);

        if (h_i == H_TOTAL - 1) begin
            h_d = '0;
            v_d = (v_i == V_TOTAL - 1) ? '0 : VW'(v_i + 1);
        end else begin
            h_d = HW'(h_i + 1);
            v_d = v_q;
        end

        // At the first pixel of a frame the new enable value applies
        // immediately, so the whole frame is drawn with one setting.
        en_d = frame_first ? i_enable : en_q;

        // The row address is set at the start of horizontal blank. The cell
        // array then has two clocks before the row is captured.
        row_d = row_q;
        buf_d = buf_q;
        if (vn_grid && (h_i == H_VISIBLE)) begin
            row_d = RW'((vn - Y_OFFSET) >> CELL_SHIFT);
        end
        if (vn_grid && (h_i == H_VISIBLE + 2)) begin
            buf_d = i_cells;
        end

        pix_d = 2'b00;
        if (en_d && in_grid) begin
            if ((GRID_LINES != 0) && (((hx & CELL_MASK) == 0) || ((vy & CELL_MASK) == 0))) begin
                pix_d = 2'b11;
            end else if (buf_q[CW'(hx >> CELL_SHIFT)]) begin
                pix_d = 2'b10;
            end else begin
                pix_d = 2'b01;
            end
        end

        hs_d = ((h_i >= HS_START) && (h_i < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vs_d = ((v_i >= VS_START) && (v_i < VS_END)) ? SYNC_POL : ~SYNC_POL;
        fs_d = frame_first;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q   <= '0;
            v_q   <= '0;
            en_q  <= 1'b0;
            row_q <= '0;
            buf_q <= '0;
            pix_q <= 2'b00;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            fs_q  <= 1'b0;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            en_q  <= en_d;
            row_q <= row_d;
            buf_q <= buf_d;
            pix_q <= pix_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            fs_q  <= fs_d;
        end
    end

    assign o_row_select  = row_q;
    assign o_hsync       = hs_q;
    assign o_vsync       = vs_q;
    assign o_pixel       = pix_q;
    assign o_frame_start = fs_q;

endmodule

// File: tb/tb_silife_vga_grid.sv
// Testbench for silife_vga_grid. It uses a reduced screen timing so that
// several frames run quickly: 80 x 56 total, 64 x 48 visible, an 8 x 8 grid of
// 4-pixel cells at offset (8,4), with grid lines drawn.
module tb_silife_vga_grid;

    localparam int HV = 64, HFP = 4, HS = 8, HBP = 4, HT = HV + HFP + HS + HBP;
    localparam int VV = 48, VFP = 2, VS = 2, VBP = 4, VT = VV + VFP + VS + VBP;
    localparam int W = 8, H = 8, CS = 2, CELL = 4, X0 = 8, Y0 = 4;
    localparam int FRAME = HT * VT;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         i_enable = 1'b0;
    logic [W-1:0] i_cells;
    logic [2:0]   o_row_select;
    logic         o_hsync, o_vsync, o_frame_start;
    logic [1:0]   o_pixel;

    logic [W-1:0] mem [H];
    assign i_cells = mem[o_row_select];

    always #5 clk = ~clk;

    silife_vga_grid #(
        .WIDTH(W), .HEIGHT(H), .CELL_SHIFT(CS), .X_OFFSET(X0), .Y_OFFSET(Y0), .GRID_LINES(1),
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .i_enable(i_enable), .i_cells(i_cells),
        .o_row_select(o_row_select), .o_hsync(o_hsync), .o_vsync(o_vsync),
        .o_pixel(o_pixel), .o_frame_start(o_frame_start)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model. It works directly from screen coordinates.
    int           mh, mv, m_row, m_vn, out_x, out_y;
    logic [W-1:0] m_buf;
    logic         m_en, out_valid, chk_on = 1'b0;
    logic [1:0]   e_pix;
    logic         e_hs, e_vs, e_fs;
    logic [1:0]   cap [VT][HT];

    function automatic logic [1:0] ref_pix(int x, int y, logic [W-1:0] b, logic en);
        if (!en) return 2'b00;
        if (x < X0 || x >= X0 + W * CELL || y < Y0 || y >= Y0 + H * CELL) return 2'b00;
        if (((x - X0) % CELL) == 0 || ((y - Y0) % CELL) == 0) return 2'b11;
        return b[(x - X0) / CELL] ? 2'b10 : 2'b01;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mh = 0; mv = 0; m_row = 0; m_buf = '0; m_en = 1'b0;
            e_pix = 2'b00; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; out_valid = 1'b0;
        end else begin
            e_fs = (mh == 0 && mv == 0);
            if (e_fs) m_en = i_enable;
            e_pix = ref_pix(mh, mv, m_buf, m_en);
            e_hs = !(mh >= HV + HFP && mh < HV + HFP + HS);
            e_vs = !(mv >= VV + VFP && mv < VV + VFP + VS);
            m_vn = (mv + 1) % VT;
            if (m_vn >= Y0 && m_vn < Y0 + H * CELL) begin
                if (mh == HV) m_row = (m_vn - Y0) / CELL;
                if (mh == HV + 2) m_buf = mem[m_row];
            end
            out_x = mh; out_y = mv; out_valid = 1'b1;
            mh = mh + 1;
            if (mh == HT) begin
                mh = 0;
                mv = (mv + 1) % VT;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            n_vec++;
            if (o_pixel !== e_pix || o_hsync !== e_hs || o_vsync !== e_vs ||
                o_frame_start !== e_fs || o_row_select !== 3'(m_row)) begin
                n_err++;
                if (n_err <= 20)
                    $display("FAIL model (x=%0d,y=%0d): got pix=%0d hs=%0b vs=%0b fs=%0b row=%0d, want pix=%0d hs=%0b vs=%0b fs=%0b row=%0d",
                             out_x, out_y, o_pixel, o_hsync, o_vsync, o_frame_start, o_row_select,
                             e_pix, e_hs, e_vs, e_fs, m_row);
            end
            if (out_valid) cap[out_y][out_x] = o_pixel;
        end
    end

    task automatic check(string name, int got, int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic wait_pos(int x, int y);
        int k = 0;
        while (!(mh == x && mv == y) && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        if (!(mh == x && mv == y)) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_pos(%0d,%0d): timed out", x, y);
        end
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_pix"}, int'(o_pixel), 0);
        check({tag, "_hsync"}, int'(o_hsync), 1);
        check({tag, "_vsync"}, int'(o_vsync), 1);
        check({tag, "_fs"}, int'(o_frame_start), 0);
        check({tag, "_row"}, int'(o_row_select), 0);
    endtask

    typedef struct {
        int         x;
        int         y;
        logic [1:0] exp;
    } vec_t;
    vec_t tbl [14];

    int hs_lo, vs_lo, fs_n, nz, k;

    initial begin
        // Expected pixel classes with mem[r] = 1 << r (the diagonal is alive).
        tbl[0]  = '{8, 4, 2'b11};   // grid origin is a line pixel
        tbl[1]  = '{7, 4, 2'b00};   // just left of the grid
        tbl[2]  = '{9, 5, 2'b10};   // cell (0,0) alive
        tbl[3]  = '{13, 5, 2'b01};  // cell (1,0) dead
        tbl[4]  = '{13, 9, 2'b10};  // cell (1,1) alive
        tbl[5]  = '{12, 9, 2'b11};  // vertical line
        tbl[6]  = '{10, 8, 2'b11};  // horizontal line
        tbl[7]  = '{39, 35, 2'b10}; // last pixel of cell (7,7)
        tbl[8]  = '{40, 35, 2'b00}; // right of the grid
        tbl[9]  = '{39, 36, 2'b00}; // below the grid
        tbl[10] = '{33, 33, 2'b01}; // cell (6,7) dead
        tbl[11] = '{50, 10, 2'b00}; // visible, outside the grid
        tbl[12] = '{20, 2, 2'b00};  // above the grid
        tbl[13] = '{70, 10, 2'b00}; // horizontal blank

        for (int r = 0; r < H; r++) mem[r] = W'(1 << r);
        i_enable = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        chk_on = 1'b1;
        reset = 1'b0;

        // First frame: sync pulse counts and the frame_start pulse.
        hs_lo = 0; vs_lo = 0; fs_n = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (i == 0) check("fs_first_cycle", int'(o_frame_start), 1);
            hs_lo += int'(!o_hsync);
            vs_lo += int'(!o_vsync);
            fs_n  += int'(o_frame_start);
        end
        check("hsync_low_per_frame", hs_lo, HS * VT);
        check("vsync_low_per_frame", vs_lo, VS * HT);
        check("fs_per_frame", fs_n, 1);
        for (int i = 0; i < 14; i++)
            check($sformatf("pix(%0d,%0d)", tbl[i].x, tbl[i].y),
                  int'(cap[tbl[i].y][tbl[i].x]), int'(tbl[i].exp));

        // Change the cells mid-line. Line 10 keeps the old row, and line 11
        // fetches the new one.
        wait_pos(20, 10);
        mem[1] = 8'hFD;
        wait_pos(0, 13);
        check("tear_old_before", int'(cap[10][13]), 2);
        check("tear_old_after", int'(cap[10][29]), 1);
        check("tear_new_dead", int'(cap[11][13]), 1);
        check("tear_new_alive", int'(cap[11][9]), 2);
        mem[1] = 8'h02;

        // Drop enable mid-frame. This frame is still drawn; the next frame is blank.
        wait_pos(0, 20);
        i_enable = 1'b0;
        nz = 0; k = 0;
        while (!(mh == 0 && mv == 0) && k < 2 * FRAME) begin
            @(negedge clk);
            nz += int'(o_pixel != 2'b00);
            k++;
        end
        check("en_drop_current_frame_drawn", int'(nz > 0), 1);
        nz = 0; hs_lo = 0; fs_n = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            nz    += int'(o_pixel != 2'b00);
            hs_lo += int'(!o_hsync);
            fs_n  += int'(o_frame_start);
        end
        check("disabled_frame_nonzero_pixels", nz, 0);
        check("disabled_frame_hsync_low", hs_lo, HS * VT);
        check("disabled_frame_fs", fs_n, 1);
        i_enable = 1'b1;

        // One-cycle reset in the middle of a frame.
        wait_pos(30, 20);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("midreset");
        reset = 1'b0;
        @(negedge clk);
        check("midreset_fs", int'(o_frame_start), 1);

        // Random cell updates, enable toggles and occasional reset pulses.
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            k = int'($urandom_range(0, 999));
            reset = (k == 999);
            if (k < 20) mem[$urandom_range(0, H - 1)] = W'($urandom);
            else if (k < 23) i_enable = ~i_enable;
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
